// File: rtl/ucaspian_pkg.sv
// Shared opcodes, packet kinds and lengths for the uCaspian host byte-stream path.
package ucaspian_pkg;

  localparam logic [3:0] OPC_ACK  = 4'h1;
  localparam logic [7:0] OPC_FIRE = 8'h20;
  localparam logic [7:0] OPC_TIME = 8'h30;

  localparam logic [1:0] LEN_ACK  = 2'd1;
  localparam logic [1:0] LEN_FIRE = 2'd2;
  localparam logic [1:0] LEN_TIME = 2'd3;

  typedef enum logic [1:0] {
    PKT_NONE = 2'd0,
    PKT_ACK  = 2'd1,
    PKT_FIRE = 2'd2,
    PKT_TIME = 2'd3
  } pkt_kind_t;

endpackage

// File: rtl/ucaspian_tx_packetizer_if.sv
// Source handshakes plus the device-to-host byte channel of the tx packetizer.
interface ucaspian_tx_packetizer_if #(
  parameter int TIME_W = 16
);
  logic              ack_vld;
  logic [3:0]        ack_code;
  logic              ack_rdy;
  logic              fire_vld;
  logic [7:0]        fire_id;
  logic              fire_rdy;
  logic              time_vld;
  logic [TIME_W-1:0] time_val;
  logic              time_rdy;
  logic [7:0]        read_data;
  logic              read_vld;
  logic              read_rdy;

  // Environment side: packet sources and the host consumer.
  modport master (
    output ack_vld, ack_code, fire_vld, fire_id, time_vld, time_val, read_rdy,
    input  ack_rdy, fire_rdy, time_rdy, read_data, read_vld
  );

  // Packetizer side.
  modport slave (
    input  ack_vld, ack_code, fire_vld, fire_id, time_vld, time_val, read_rdy,
    output ack_rdy, fire_rdy, time_rdy, read_data, read_vld
  );
endinterface

// File: rtl/ucaspian_tx_packetizer_arb.sv
// Fixed-priority (ACK > FIRE > TIME) source arbiter, purely combinational.
module ucaspian_tx_arb
  import ucaspian_pkg::*;
(
  input  logic      grant,
  input  logic      ack_vld,
  input  logic      fire_vld,
  input  logic      time_vld,
  output pkt_kind_t kind,
  output logic [2:0] rdy   // {time, fire, ack}
);

  always_comb begin
    kind = PKT_NONE;
    rdy  = 3'b000;
    if (grant) begin
      if (ack_vld) begin
        kind = PKT_ACK;
        rdy  = 3'b001;
      end else if (fire_vld) begin
        kind = PKT_FIRE;
        rdy  = 3'b010;
      end else if (time_vld) begin
        kind = PKT_TIME;
        rdy  = 3'b100;
      end
    end
  end

endmodule

// File: rtl/ucaspian_tx_packetizer.sv
// Frames ack/fire/time events into 1-3 byte packets and streams them to the host.
module ucaspian_tx_packetizer
  import ucaspian_pkg::*;
#(
  parameter int TIME_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  ucaspian_tx_packetizer_if.slave bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        tx_bytes
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state_q;
  logic [23:0]      sreg_q;
  logic [1:0]       rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic              hs, last_byte, grant, accept;
  logic [2:0]        rdy;
  pkt_kind_t         kind;
  logic [23:0]       frame;
  logic [1:0]        frame_len;
  logic [TIME_W-1:0] tval;

  assign tval      = bus.time_val;
  assign hs        = bus.read_vld & bus.read_rdy;
  assign last_byte = (rem_q == 2'd1);
  // Reset gates the grant so no source sees rdy while reset_n is low.
  assign grant     = reset_n & ((state_q == IDLE) | (hs & last_byte));
  assign accept    = (kind != PKT_NONE);

  ucaspian_tx_arb u_arb (
    .grant    (grant),
    .ack_vld  (bus.ack_vld),
    .fire_vld (bus.fire_vld),
    .time_vld (bus.time_vld),
    .kind     (kind),
    .rdy      (rdy)
  );

  assign bus.ack_rdy  = rdy[0];
  assign bus.fire_rdy = rdy[1];
  assign bus.time_rdy = rdy[2];

  // Byte 0 sits in the top byte of the frame; unused tail bytes are zero.
  always_comb begin
    frame     = 24'h0;
    frame_len = 2'd0;
    case (kind)
      PKT_ACK: begin
        frame     = {OPC_ACK, bus.ack_code, 16'h0};
        frame_len = LEN_ACK;
      end
      PKT_FIRE: begin
        frame     = {OPC_FIRE, bus.fire_id, 8'h0};
        frame_len = LEN_FIRE;
      end
      PKT_TIME: begin
        frame     = {OPC_TIME, tval[15:0]};
        frame_len = LEN_TIME;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= 24'h0;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      if (hs) cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        state_q <= SEND;
        sreg_q  <= frame;
        rem_q   <= frame_len;
      end else if (hs) begin
        if (last_byte) begin
          state_q <= IDLE;
          sreg_q  <= 24'h0;
          rem_q   <= 2'd0;
        end else begin
          sreg_q <= {sreg_q[15:0], 8'h0};
          rem_q  <= rem_q - 2'd1;
        end
      end
    end
  end

  assign bus.read_vld  = (state_q == SEND);
  assign bus.read_data = sreg_q[23:16];
  assign busy          = (state_q == SEND);
  assign tx_bytes      = cnt_q;

endmodule
